// File: rtl/dmem_byte_arbiter.sv
// Two word requesters (C = processor, A = aux/debug) sharing one byte-wide memory; each word is 4 big-endian byte beats.
// Optional define MISALIGN_TRAP_EN: unaligned word addresses ack immediately with err and never touch memory.
module dmem_byte_arbiter #(
    parameter int ADDR_W = 5,
    parameter bit RR     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_ack,
    output logic [31:0]       c_rdata,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_ack,
    output logic [31:0]       a_rdata,
    output logic              err,
    output logic              busy,
    output logic              gnt_id,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT, TAIL, DONE} state_t;

    state_t              state_q;
    logic [1:0]          k_q;
    logic                we_q;
    logic [23:0]         wsh_q;
    logic [23:0]         stage_q;
    logic                gnt_q;
    logic                last_q;
    logic                c_ack_q;
    logic                a_ack_q;
    logic                err_q;
    logic [31:0]         c_rdata_q;
    logic [31:0]         a_rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [7:0]          mem_wdata_q;

    logic                sel_a;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;

    // A wins alone, or on a tie when round-robin and C was granted last.
    always_comb begin
        sel_a     = a_req && (!c_req || (RR && !last_q));
        sel_we    = sel_a ? a_we    : c_we;
        sel_addr  = sel_a ? a_addr  : c_addr;
        sel_wdata = sel_a ? a_wdata : c_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            we_q        <= 1'b0;
            wsh_q       <= 24'h0;
            stage_q     <= 24'h0;
            gnt_q       <= 1'b1;
            last_q      <= 1'b1;
            c_ack_q     <= 1'b0;
            a_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            c_rdata_q   <= 32'h0;
            a_rdata_q   <= 32'h0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h0;
        end else begin
            c_ack_q <= 1'b0;
            a_ack_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (c_req || a_req) begin
                        gnt_q <= sel_a;
                        we_q  <= sel_we;
                        wsh_q <= sel_wdata[23:0];
`ifdef MISALIGN_TRAP_EN
                        if (sel_addr[1:0] != 2'b00) begin
                            state_q <= DONE;
                            err_q   <= 1'b1;
                            c_ack_q <= !sel_a;
                            a_ack_q <= sel_a;
                        end else
`endif
                        begin
                            state_q     <= BEAT;
                            k_q         <= 2'd0;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= sel_we;
                            mem_addr_q  <= sel_addr;
                            mem_wdata_q <= sel_wdata[31:24];
                        end
                    end
                end
                BEAT: begin
                    // Read data trails the strobe by one cycle, so beat k captures byte k-1.
                    if (!we_q && k_q != 2'd0) begin
                        stage_q <= {stage_q[15:0], mem_rdata};
                    end
                    if (k_q == 2'd3) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (we_q) begin
                            state_q <= DONE;
                            c_ack_q <= !gnt_q;
                            a_ack_q <= gnt_q;
                        end else begin
                            state_q <= TAIL;
                        end
                    end else begin
                        k_q         <= k_q + 2'd1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                        mem_wdata_q <= wsh_q[23:16];
                        wsh_q       <= {wsh_q[15:0], 8'h00};
                    end
                end
                TAIL: begin
                    state_q <= DONE;
                    c_ack_q <= !gnt_q;
                    a_ack_q <= gnt_q;
                    if (gnt_q) begin
                        a_rdata_q <= {stage_q, mem_rdata};
                    end else begin
                        c_rdata_q <= {stage_q, mem_rdata};
                    end
                end
                DONE: begin
                    last_q  <= gnt_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c_ack     = c_ack_q;
    assign a_ack     = a_ack_q;
    assign err       = err_q;
    assign c_rdata   = c_rdata_q;
    assign a_rdata   = a_rdata_q;
    assign busy      = (state_q != IDLE);
    assign gnt_id    = gnt_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
